// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared constants and types for the PPU scanline buffer.
//   LINE_W    pixels per NES line (power of two)
//   IDX_W     system palette index width
//   FILL_IDX  index shown when no completed line is available (black)
//   CNT_W     underrun counter width
//   NES_H     visible NES lines; the renderer ignores requests at or above it
//   wr_state_t  renderer-side fill state (FILL = accepting, DONE = line full)
// ---------------------------------------------------------------------------
package ppu_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = $clog2(LINE_W);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 8;
    localparam int NES_H  = 240;

    localparam logic [IDX_W-1:0] FILL_IDX = 6'h0f;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } wr_state_t;

    // True when a 10-bit NES x coordinate falls inside the stored line.
    function automatic logic x_in_line(input logic [9:0] x);
        return x < 10'(LINE_W);
    endfunction

endpackage

// File: rtl/ppu_line_ram.sv
// ---------------------------------------------------------------------------
// ppu_line_ram
// Simple dual-port line memory holding both ping-pong banks
// (2*LINE_W x IDX_W). Address MSB selects the bank, low bits the NES x.
// Contents are not reset; written data is only read after a full line swap.
//   clk_in   system clock
//   wr_en    write strobe
//   wr_addr  {bank, x} write address
//   wr_data  palette index to store
//   rd_addr  {bank, x} read address
//   rd_data  registered read data (one clock after rd_addr)
// ---------------------------------------------------------------------------
module ppu_line_ram
    import ppu_pkg::*;
(
    input  logic              clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [IDX_W-1:0]  wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [IDX_W-1:0]  rd_data
);

    logic [IDX_W-1:0] mem [2*LINE_W];

    // Plain synchronous write plus registered read so the memory maps onto
    // a block RAM with no reset and no read-during-write bypass needed
    // (the two banks are never the same).
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ppu_line_buf.sv
// ---------------------------------------------------------------------------
// ppu_line_buf
// Ping-pong scanline buffer between the PPU renderer and the VGA block.
// The renderer fills the write bank through a valid/ready handshake; the VGA
// side reads the other bank by NES x. Banks swap whenever the VGA NES y
// changes. An incomplete line at swap time is dropped and counted as an
// underrun, and the previous line repeats on screen.
//   clk_in               system clock
//   rst_n_in             asynchronous active-low reset
//   wr_valid_in          renderer pixel valid
//   wr_ready_out         buffer can accept a pixel
//   wr_idx_in            renderer palette index
//   wr_line_out          NES line the renderer must produce next
//   fill_start_out       1-clk pulse when a new fill begins
//   nes_x_in / nes_y_in  VGA-side NES coordinates
//   sys_palette_idx_out  palette index to VGA (1-clk read latency)
//   underrun_out         1-clk pulse: swap hit an incomplete line
//   underrun_cnt_out     saturating underrun count
// ---------------------------------------------------------------------------
module ppu_line_buf
    import ppu_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              wr_valid_in,
    output logic              wr_ready_out,
    input  logic [IDX_W-1:0]  wr_idx_in,
    output logic [9:0]        wr_line_out,
    output logic              fill_start_out,
    input  logic [9:0]        nes_x_in,
    input  logic [9:0]        nes_y_in,
    output logic [IDX_W-1:0]  sys_palette_idx_out,
    output logic              underrun_out,
    output logic [CNT_W-1:0]  underrun_cnt_out
);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    wr_state_t         state_q;
    wr_state_t         state_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic              rd_bank_q;
    logic              rd_valid_q;
    logic              rd_hit_q;
    logic [9:0]        q_nes_y;
    logic              accept;
    logic              last_pix;
    logic              line_complete;
    logic              swap;
    logic [IDX_W-1:0]  ram_rd_data;

    // Reset asserts asynchronously but releases on a clock edge, so every
    // flop below leaves reset in the same cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // A line counts as complete if it was already full, or if its last pixel
    // is accepted in the same cycle as the swap.
    assign accept        = wr_valid_in && (state_q == FILL);
    assign last_pix      = accept && (wr_ptr_q == PTR_W'(LINE_W - 1));
    assign line_complete = (state_q == DONE) || last_pix;
    assign swap          = (nes_y_in != q_nes_y);

    // Fill state register.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake: a swap always restarts the fill, otherwise
    // the line closes on its last accepted pixel.
    always_comb begin
        state_d      = state_q;
        wr_ready_out = 1'b0;
        case (state_q)
            FILL: begin
                wr_ready_out = 1'b1;
                if (last_pix) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wr_ready_out = 1'b0;
            end
            default: begin
                state_d = FILL;
            end
        endcase
        if (swap) begin
            state_d = FILL;
        end
    end

    // Write pointer: counts accepted pixels and parks at LINE_W when full;
    // any swap discards what was written and starts over.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
        end else if (swap) begin
            wr_ptr_q <= '0;
        end else if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // Swap handling: complete lines flip the banks, incomplete ones leave the
    // read bank alone and bump the saturating underrun counter. The renderer
    // is told which line to produce next.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_q        <= 1'b0;
            rd_valid_q       <= 1'b0;
            q_nes_y          <= '0;
            wr_line_out      <= 10'd1;
            fill_start_out   <= 1'b0;
            underrun_out     <= 1'b0;
            underrun_cnt_out <= '0;
        end else begin
            q_nes_y        <= nes_y_in;
            fill_start_out <= swap;
            underrun_out   <= swap && !line_complete;
            if (swap) begin
                wr_line_out <= nes_y_in + 10'd1;
                if (line_complete) begin
                    rd_bank_q  <= ~rd_bank_q;
                    rd_valid_q <= 1'b1;
                end else if (underrun_cnt_out != '1) begin
                    underrun_cnt_out <= underrun_cnt_out + 1'b1;
                end
            end
        end
    end

    // Read qualifier, aligned with the RAM's registered read data. It uses
    // the bank selection of the current cycle, so a read in the swap cycle
    // still comes from the old bank.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit_q <= 1'b0;
        end else begin
            rd_hit_q <= rd_valid_q && x_in_line(nes_x_in);
        end
    end

    ppu_line_ram u_ram (
        .clk_in  (clk_in),
        .wr_en   (accept),
        .wr_addr ({~rd_bank_q, wr_ptr_q[ADDR_W-1:0]}),
        .wr_data (wr_idx_in),
        .rd_addr ({rd_bank_q, nes_x_in[ADDR_W-1:0]}),
        .rd_data (ram_rd_data)
    );

    assign sys_palette_idx_out = rd_hit_q ? ram_rd_data : FILL_IDX;

endmodule

// File: tb/tb_ppu_line_buf.sv
// ---------------------------------------------------------------------------
// tb_ppu_line_buf
// Self-checking bench for ppu_line_buf. The bench keeps its own image of the
// line that should be on screen; each read pushes the expected index into a
// queue which is popped when the registered output appears.
// ---------------------------------------------------------------------------
module tb_ppu_line_buf;

    logic       clk_in;
    logic       rst_n_in;
    logic       wr_valid_in;
    logic       wr_ready_out;
    logic [5:0] wr_idx_in;
    logic [9:0] wr_line_out;
    logic       fill_start_out;
    logic [9:0] nes_x_in;
    logic [9:0] nes_y_in;
    logic [5:0] sys_palette_idx_out;
    logic       underrun_out;
    logic [7:0] underrun_cnt_out;

    int         n_checks;
    int         n_fail;
    logic [5:0] ref_line [256];
    logic [5:0] pend [256];
    bit         ref_valid;
    int         exp_cnt;
    logic [5:0] exp_q [$];

    ppu_line_buf dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .wr_valid_in         (wr_valid_in),
        .wr_ready_out        (wr_ready_out),
        .wr_idx_in           (wr_idx_in),
        .wr_line_out         (wr_line_out),
        .fill_start_out      (fill_start_out),
        .nes_x_in            (nes_x_in),
        .nes_y_in            (nes_y_in),
        .sys_palette_idx_out (sys_palette_idx_out),
        .underrun_out        (underrun_out),
        .underrun_cnt_out    (underrun_cnt_out)
    );

    // 100 MHz bench clock; the design has no frequency dependence.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [5:0] pix(input int i, input int mul, input int add);
        return 6'((i * mul + add) & 63);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Pushes n pixels starting at x=0; ready must be high for every one.
    task automatic push_line(input int n, input int mul, input int add);
        for (int i = 0; i < n; i++) begin
            pend[i]     = pix(i, mul, add);
            wr_idx_in   = pend[i];
            wr_valid_in = 1'b1;
            n_checks++;
            if (wr_ready_out !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL push_ready x=%0d got=%b exp=1", i, wr_ready_out);
            end
            tick();
        end
        wr_valid_in = 1'b0;
    endtask

    // One read through the scoreboard: expected value queued at drive time.
    task automatic read_check(input int x);
        logic [5:0] expv;
        logic [5:0] gotexp;
        if (ref_valid && x < 256) expv = ref_line[x];
        else expv = 6'h0f;
        exp_q.push_back(expv);
        nes_x_in = 10'(x);
        tick();
        gotexp = exp_q.pop_front();
        n_checks++;
        if (sys_palette_idx_out !== gotexp) begin
            n_fail++;
            $display("[TB] FAIL read x=0x%0h got=%h exp=%h", x, sys_palette_idx_out, gotexp);
        end
    endtask

    task automatic accept_line();
        for (int i = 0; i < 256; i++) ref_line[i] = pend[i];
        ref_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        wr_valid_in = 1'b0;
        wr_idx_in = '0;
        nes_x_in = '0;
        nes_y_in = '0;
        repeat (2) tick();
        n_checks++;
        if (wr_ready_out !== 1'b1 || wr_line_out !== 10'd1 || fill_start_out !== 1'b0 ||
            underrun_out !== 1'b0 || underrun_cnt_out !== 8'd0 || sys_palette_idx_out !== 6'h0f) begin
            n_fail++;
            $display("[TB] FAIL reset_state got rdy=%b line=%0d fs=%b ur=%b cnt=%0d idx=%h exp 1/1/0/0/0/0f",
                     wr_ready_out, wr_line_out, fill_start_out, underrun_out, underrun_cnt_out, sys_palette_idx_out);
        end
        rst_n_in = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (wr_ready_out !== 1'b1 || wr_line_out !== 10'd1 || underrun_cnt_out !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL post_release got rdy=%b line=%0d cnt=%0d exp 1/1/0",
                     wr_ready_out, wr_line_out, underrun_cnt_out);
        end
        ref_valid = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_no_write_underrun();
        nes_y_in = 10'd5;
        tick();
        exp_cnt++;
        n_checks++;
        if (underrun_out !== 1'b1 || fill_start_out !== 1'b1 || wr_line_out !== 10'd6 ||
            underrun_cnt_out !== 8'(exp_cnt)) begin
            n_fail++;
            $display("[TB] FAIL first_underrun got ur=%b fs=%b line=%0d cnt=%0d exp 1/1/6/%0d",
                     underrun_out, fill_start_out, wr_line_out, underrun_cnt_out, exp_cnt);
        end
        tick();
        n_checks++;
        if (underrun_out !== 1'b0 || fill_start_out !== 1'b0 || underrun_cnt_out !== 8'(exp_cnt)) begin
            n_fail++;
            $display("[TB] FAIL underrun_pulse got ur=%b fs=%b cnt=%0d exp 0/0/%0d",
                     underrun_out, fill_start_out, underrun_cnt_out, exp_cnt);
        end
        read_check(0);
        read_check(32'h41);
        read_check(255);
        read_check(32'h100);
        read_check(1023);
    endtask

    task automatic test_full_line();
        push_line(256, 1, 0);
        wr_valid_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (wr_ready_out !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL ready_after_full k=%0d got=%b exp=0", k, wr_ready_out);
            end
            tick();
        end
        wr_valid_in = 1'b0;
        nes_y_in = 10'd6;
        tick();
        accept_line();
        n_checks++;
        if (underrun_out !== 1'b0 || fill_start_out !== 1'b1 || wr_line_out !== 10'd7 ||
            underrun_cnt_out !== 8'(exp_cnt) || wr_ready_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_swap got ur=%b fs=%b line=%0d cnt=%0d rdy=%b exp 0/1/7/%0d/1",
                     underrun_out, fill_start_out, wr_line_out, underrun_cnt_out, wr_ready_out, exp_cnt);
        end
        read_check(32'h41);
        read_check(32'h100);
        read_check(0);
        read_check(255);
        read_check(32'h80);
    endtask

    task automatic test_same_cycle_swap();
        logic [5:0] old_exp;
        logic [5:0] got_old;
        push_line(255, 3, 7);
        pend[255]   = pix(255, 3, 7);
        wr_idx_in   = pend[255];
        wr_valid_in = 1'b1;
        nes_y_in    = 10'd7;
        nes_x_in    = 10'h41;
        old_exp     = ref_line[8'h41];
        exp_q.push_back(old_exp);
        tick();
        wr_valid_in = 1'b0;
        got_old = exp_q.pop_front();
        n_checks++;
        if (sys_palette_idx_out !== got_old) begin
            n_fail++;
            $display("[TB] FAIL swap_cycle_read got=%h exp=%h", sys_palette_idx_out, got_old);
        end
        accept_line();
        n_checks++;
        if (underrun_out !== 1'b0 || fill_start_out !== 1'b1 || wr_line_out !== 10'd8 ||
            wr_ready_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL same_cycle_swap got ur=%b fs=%b line=%0d rdy=%b exp 0/1/8/1",
                     underrun_out, fill_start_out, wr_line_out, wr_ready_out);
        end
        read_check(255);
        read_check(32'h41);
        read_check(0);
        read_check(100);
    endtask

    task automatic test_partial_underrun();
        push_line(100, 5, 11);
        nes_y_in = 10'd8;
        tick();
        exp_cnt++;
        n_checks++;
        if (underrun_out !== 1'b1 || underrun_cnt_out !== 8'(exp_cnt) || wr_line_out !== 10'd9 ||
            wr_ready_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL partial_underrun got ur=%b cnt=%0d line=%0d rdy=%b exp 1/%0d/9/1",
                     underrun_out, underrun_cnt_out, wr_line_out, wr_ready_out, exp_cnt);
        end
        read_check(0);
        read_check(50);
        read_check(255);
        n_checks++;
        if (underrun_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL underrun_once got=%b exp=0", underrun_out);
        end
        push_line(256, 9, 2);
        n_checks++;
        if (wr_ready_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL restart_full got rdy=%b exp=0", wr_ready_out);
        end
        nes_y_in = 10'd9;
        tick();
        accept_line();
        n_checks++;
        if (underrun_out !== 1'b0 || wr_line_out !== 10'd10) begin
            n_fail++;
            $display("[TB] FAIL restart_swap got ur=%b line=%0d exp 0/10", underrun_out, wr_line_out);
        end
        read_check(0);
        read_check(1);
        read_check(99);
        read_check(200);
    endtask

    task automatic test_saturate();
        int y;
        for (int k = 0; k < 300; k++) begin
            y = (1000 + k) % 1024;
            nes_y_in = 10'(y);
            tick();
            if (exp_cnt < 255) exp_cnt++;
            n_checks++;
            if (underrun_out !== 1'b1 || underrun_cnt_out !== 8'(exp_cnt) ||
                wr_line_out !== 10'((y + 1) % 1024)) begin
                n_fail++;
                $display("[TB] FAIL saturate k=%0d got ur=%b cnt=%0d line=%0d exp 1/%0d/%0d",
                         k, underrun_out, underrun_cnt_out, wr_line_out, exp_cnt, (y + 1) % 1024);
            end
        end
        tick();
        n_checks++;
        if (underrun_cnt_out !== 8'hff || underrun_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL saturate_final got cnt=%h ur=%b exp ff/0", underrun_cnt_out, underrun_out);
        end
        read_check(1);
    endtask

    task automatic test_mid_reset();
        int x;
        x = 0;
        for (int i = 255; i >= 0; i--) if (ref_line[i] != 6'h0f) x = i;
        nes_x_in = 10'(x);
        push_line(128, 1, 1);
        n_checks++;
        if (sys_palette_idx_out !== ref_line[x]) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_read got=%h exp=%h", sys_palette_idx_out, ref_line[x]);
        end
        rst_n_in = 1'b0;
        #2;
        n_checks++;
        if (wr_ready_out !== 1'b1 || wr_line_out !== 10'd1 || sys_palette_idx_out !== 6'h0f ||
            underrun_cnt_out !== 8'd0 || underrun_out !== 1'b0 || fill_start_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got rdy=%b line=%0d idx=%h cnt=%0d ur=%b fs=%b exp 1/1/0f/0/0/0",
                     wr_ready_out, wr_line_out, sys_palette_idx_out, underrun_cnt_out, underrun_out, fill_start_out);
        end
        nes_y_in = '0;
        tick();
        tick();
        rst_n_in = 1'b1;
        repeat (3) tick();
        ref_valid = 1'b0;
        exp_cnt = 0;
        read_check(x);
        read_check(0);
    endtask

    task automatic test_back_to_back();
        push_line(256, 7, 3);
        nes_y_in = 10'd1;
        tick();
        accept_line();
        n_checks++;
        if (underrun_out !== 1'b0 || wr_line_out !== 10'd2 || underrun_cnt_out !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL b2b_swap1 got ur=%b line=%0d cnt=%0d exp 0/2/0",
                     underrun_out, wr_line_out, underrun_cnt_out);
        end
        read_check(0);
        read_check(77);
        push_line(256, 13, 5);
        nes_y_in = 10'd2;
        tick();
        accept_line();
        n_checks++;
        if (underrun_out !== 1'b0 || wr_line_out !== 10'd3) begin
            n_fail++;
            $display("[TB] FAIL b2b_swap2 got ur=%b line=%0d exp 0/3", underrun_out, wr_line_out);
        end
        read_check(0);
        read_check(77);
        read_check(255);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ref_valid = 1'b0;
        exp_cnt  = 0;
        test_reset();
        test_no_write_underrun();
        test_full_line();
        test_same_cycle_swap();
        test_partial_underrun();
        test_saturate();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
